// File: rtl/frame_streamer.sv
// Streams one frame of pixels from a ready/valid source with coordinates, then
// waits for a tracker centroid (or a timeout) before finishing or restarting.
module frame_streamer #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int RES_TIMEOUT = 4096,
    parameter int NOT_FOUND   = 2023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic        i_abort,
    input  logic        src_valid,
    input  logic [7:0]  src_r,
    input  logic [7:0]  src_g,
    input  logic [7:0]  src_b,
    output logic        src_ready,
    output logic        o_start,
    output logic        o_valid,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_frame_start,
    output logic        o_frame_end,
    input  logic        res_valid,
    input  logic [10:0] res_x,
    input  logic [10:0] res_y,
    output logic [10:0] o_cx,
    output logic [10:0] o_cy,
    output logic        o_found,
    output logic        o_done,
    output logic        o_timeout,
    output logic [15:0] o_frame_cnt
);

    localparam int          CW   = $clog2(RES_TIMEOUT) + 1;
    localparam logic [10:0] NF   = 11'(NOT_FOUND);
    localparam logic [10:0] XMAX = 11'(WIDTH - 1);
    localparam logic [10:0] YMAX = 11'(HEIGHT - 1);
    localparam logic [CW-1:0] TMAX = CW'(RES_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STREAM, S_FLUSH, S_END, S_WAIT_RES
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          pix_vld_q, pix_vld_d;
    logic          fs_q, fs_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic [10:0]   ox_q, ox_d, oy_q, oy_d;
    logic [10:0]   cx_q, cx_d, cy_q, cy_d;
    logic          found_q, found_d;
    logic          done_q, done_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   cnt_q, cnt_d;

    logic accept, last_pix;
    state_t after_res;

    assign accept    = (state_q == S_STREAM) && src_valid;
    assign last_pix  = (x_q == XMAX) && (y_q == YMAX);
    assign after_res = i_continuous ? S_START : S_IDLE;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wait_d    = wait_q;
        pix_vld_d = 1'b0;
        fs_d      = 1'b0;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        found_d   = found_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_START;
            end
            S_START: begin
                x_d     = '0;
                y_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept) begin
                    pix_vld_d = 1'b1;
                    fs_d      = (x_q == '0) && (y_q == '0);
                    r_d       = src_r;
                    g_d       = src_g;
                    b_d       = src_b;
                    ox_d      = x_q;
                    oy_d      = y_q;
                    if (x_q == XMAX) begin
                        x_d = '0;
                        y_d = y_q + 11'd1;
                    end else begin
                        x_d = x_q + 11'd1;
                    end
                end
                // Abort still lets a same-cycle accept through; it is presented in FLUSH.
                if ((accept && last_pix) || i_abort) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_END;
            end
            S_END: begin
                wait_d  = '0;
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                wait_d = wait_q + 1'b1;
                if (res_valid) begin
                    cx_d    = res_x;
                    cy_d    = res_y;
                    found_d = (res_x != NF) && (res_y != NF);
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = after_res;
                end else if (wait_q == TMAX) begin
                    cx_d    = NF;
                    cy_d    = NF;
                    found_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = after_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            wait_q    <= '0;
            pix_vld_q <= 1'b0;
            fs_q      <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            cx_q      <= NF;
            cy_q      <= NF;
            found_q   <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wait_q    <= wait_d;
            pix_vld_q <= pix_vld_d;
            fs_q      <= fs_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            found_q   <= found_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign src_ready     = (state_q == S_STREAM);
    assign o_start       = (state_q == S_START);
    assign o_frame_end   = (state_q == S_END);
    assign o_valid       = pix_vld_q;
    assign o_frame_start = fs_q;
    assign o_r           = r_q;
    assign o_g           = g_q;
    assign o_b           = b_q;
    assign o_x           = ox_q;
    assign o_y           = oy_q;
    assign o_cx          = cx_q;
    assign o_cy          = cy_q;
    assign o_found       = found_q;
    assign o_done        = done_q;
    assign o_timeout     = tmo_q;
    assign o_frame_cnt   = cnt_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Randomized bench for frame_streamer on a 4x2 frame; expected pixels come from
// the k-th accepted source pixel mapping to (k % W, k / W).
module tb_frame_streamer;

    localparam int          W  = 4;
    localparam int          H  = 2;
    localparam int          TO = 16;
    localparam logic [10:0] NF = 11'd2023;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_start, i_continuous, i_abort;
    logic        src_valid, src_ready;
    logic [7:0]  src_r, src_g, src_b;
    logic        o_start, o_valid, o_frame_start, o_frame_end;
    logic [7:0]  o_r, o_g, o_b;
    logic [10:0] o_x, o_y;
    logic        res_valid;
    logic [10:0] res_x, res_y, o_cx, o_cy;
    logic        o_found, o_done, o_timeout;
    logic [15:0] o_frame_cnt;

    typedef struct {
        logic [7:0]  r, g, b;
        logic [10:0] x, y;
    } pix_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    logic [10:0] exp_cx = NF, exp_cy = NF;
    logic        exp_found = 1'b0;

    always #5 i_clk = ~i_clk;

    frame_streamer #(.WIDTH(W), .HEIGHT(H), .RES_TIMEOUT(TO), .NOT_FOUND(2023)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_continuous(i_continuous),
        .i_abort(i_abort), .src_valid(src_valid), .src_r(src_r), .src_g(src_g),
        .src_b(src_b), .src_ready(src_ready), .o_start(o_start), .o_valid(o_valid),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_x(o_x), .o_y(o_y),
        .o_frame_start(o_frame_start), .o_frame_end(o_frame_end), .res_valid(res_valid),
        .res_x(res_x), .res_y(res_y), .o_cx(o_cx), .o_cy(o_cy), .o_found(o_found),
        .o_done(o_done), .o_timeout(o_timeout), .o_frame_cnt(o_frame_cnt)
    );

    // Caller raises i_start (or relies on continuous restart); returns at the END cycle.
    task automatic stream_frame(input int gap_pct, input int total, input bit do_abort,
                                input bit hold_start);
        pix_t q[$];
        pix_t e;
        int   acc = 0, outn = 0, rdy = 0, cyc = 0;
        bit   end_exp = 0, fin = 0;
        while (o_start !== 1'b1 && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        checks++;
        if (o_start !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: o_start=%b want 1", o_start);
            return;
        end
        checks++;
        if (src_ready !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_quiet: src_ready=%b o_valid=%b want 0 0", src_ready, o_valid);
        end
        if (!hold_start) i_start = 1'b0;
        cyc = 0;
        while (!fin && cyc < 400) begin
            @(negedge i_clk);
            cyc++;
            checks++;
            if (end_exp) begin
                fin = 1;
                if (o_frame_end !== 1'b1 || o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_end: o_frame_end=%b o_valid=%b want 1 0", o_frame_end, o_valid);
                end
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (o_valid !== 1'b1 || o_r !== e.r || o_g !== e.g || o_b !== e.b ||
                    o_x !== e.x || o_y !== e.y || o_frame_end !== 1'b0 ||
                    o_frame_start !== ((e.x == 0) && (e.y == 0)) || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL pixel %0d: got v=%b rgb=%h%h%h xy=(%0d,%0d) fs=%b fe=%b want rgb=%h%h%h xy=(%0d,%0d)",
                             outn, o_valid, o_r, o_g, o_b, o_x, o_y, o_frame_start, o_frame_end,
                             e.r, e.g, e.b, e.x, e.y);
                end
                outn++;
                if (outn == total) end_exp = 1;
            end else begin
                if (o_valid !== 1'b0 || o_frame_end !== 1'b0 || o_frame_start !== 1'b0 ||
                    o_done !== 1'b0 || o_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_quiet: v=%b fe=%b fs=%b done=%b tmo=%b want all 0",
                             o_valid, o_frame_end, o_frame_start, o_done, o_timeout);
                end
            end
            if (!fin) begin
                if (src_ready === 1'b1) rdy++;
                if (acc < total) begin
                    src_valid = ($urandom_range(99) >= gap_pct);
                    src_r = 8'($urandom_range(255));
                    src_g = 8'($urandom_range(255));
                    src_b = 8'($urandom_range(255));
                    i_abort = do_abort && (acc == total - 1);
                    if (i_abort) src_valid = 1'b1;
                end else begin
                    src_valid = 1'b0;
                    i_abort   = 1'b0;
                end
                if (src_valid && src_ready === 1'b1) begin
                    q.push_back('{src_r, src_g, src_b, 11'(acc % W), 11'(acc / W)});
                    acc++;
                end
            end
        end
        src_valid = 1'b0;
        i_abort   = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: %0d of %0d pixels out, no frame end", outn, total);
        end
        if (gap_pct == 0) begin
            checks++;
            if (rdy != total) begin
                errors++;
                $display("FAIL ready_cycles: got %0d want %0d", rdy, total);
            end
        end
    endtask

    // Called at the END cycle; result lands while the wait counter equals delay.
    task automatic deliver_result(input int delay, input logic [10:0] rx, input logic [10:0] ry);
        bit quiet = 1;
        for (int j = 0; j <= delay; j++) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_timeout !== 1'b0 || o_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL wait_quiet: pulse seen while waiting for result");
        end
        res_valid = 1'b1;
        res_x     = rx;
        res_y     = ry;
        @(negedge i_clk);
        res_valid = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        exp_cx    = rx;
        exp_cy    = ry;
        exp_found = (rx != NF) && (ry != NF);
        checks++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0 || o_cx !== exp_cx || o_cy !== exp_cy ||
            o_found !== exp_found || o_frame_cnt !== exp_cnt || o_start !== i_continuous) begin
            errors++;
            $display("FAIL result: done=%b tmo=%b c=(%0d,%0d) found=%b cnt=%0d start=%b want 1 0 (%0d,%0d) %b %0d %b",
                     o_done, o_timeout, o_cx, o_cy, o_found, o_frame_cnt, o_start,
                     exp_cx, exp_cy, exp_found, exp_cnt, i_continuous);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 0; i_continuous = 0; i_abort = 0;
        src_valid = 0; src_r = 0; src_g = 0; src_b = 0;
        res_valid = 0; res_x = 0; res_y = 0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_valid !== 0 || o_start !== 0 || o_frame_end !== 0 || o_frame_start !== 0 ||
            src_ready !== 0 || o_done !== 0 || o_timeout !== 0 || o_cx !== NF || o_cy !== NF ||
            o_found !== 0 || o_frame_cnt !== 0 || o_r !== 0 || o_g !== 0 || o_b !== 0 ||
            o_x !== 0 || o_y !== 0) begin
            errors++;
            $display("FAIL reset_values: v=%b st=%b rdy=%b c=(%0d,%0d) cnt=%0d", o_valid, o_start,
                     src_ready, o_cx, o_cy, o_frame_cnt);
        end
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checks++;
            if (src_ready !== 0 || o_start !== 0) begin
                errors++;
                $display("FAIL idle_hold: rdy=%b start=%b want 0 0", src_ready, o_start);
            end
        end
    endtask

    task automatic test_full_frame();
        i_start = 1'b1;
        stream_frame(0, W * H, 0, 0);
        deliver_result(3, 11'd123, 11'd45);
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_start !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b start=%b want 0 0", o_done, o_start);
        end
    endtask

    // i_start stays high throughout the frame and must not disturb it.
    task automatic test_gaps_not_found();
        i_start = 1'b1;
        stream_frame(40, W * H, 0, 1);
        i_start = 1'b0;
        deliver_result(0, NF, 11'd7);
    endtask

    task automatic test_ignored_inputs();
        @(negedge i_clk);
        res_valid = 1'b1; res_x = 11'd5; res_y = 11'd6; i_abort = 1'b1;
        repeat (3) @(negedge i_clk);
        res_valid = 1'b0;
        checks++;
        if (o_done !== 0 || o_cx !== exp_cx || o_cy !== exp_cy || o_frame_cnt !== exp_cnt ||
            src_ready !== 0) begin
            errors++;
            $display("FAIL res_ignored: done=%b c=(%0d,%0d) cnt=%0d want 0 (%0d,%0d) %0d",
                     o_done, o_cx, o_cy, o_frame_cnt, exp_cx, exp_cy, exp_cnt);
        end
        i_start = 1'b1;
        stream_frame(25, W * H, 0, 0);
        deliver_result(2, 11'd9, 11'd10);
    endtask

    task automatic test_timeout();
        bit quiet = 1;
        i_start = 1'b1;
        stream_frame(20, W * H, 0, 0);
        for (int j = 1; j <= TO; j++) begin
            @(negedge i_clk);
            if (o_timeout !== 1'b0 || o_done !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL timeout_early: pulse before %0d wait cycles", TO);
        end
        @(negedge i_clk);
        exp_cx = NF; exp_cy = NF; exp_found = 0;
        checks++;
        if (o_timeout !== 1'b1 || o_done !== 1'b0 || o_cx !== NF || o_cy !== NF ||
            o_found !== 1'b0 || o_frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL timeout: tmo=%b done=%b c=(%0d,%0d) found=%b cnt=%0d want 1 0 (2023,2023) 0 %0d",
                     o_timeout, o_done, o_cx, o_cy, o_found, o_frame_cnt, exp_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_timeout !== 0 || src_ready !== 0 || o_start !== 0) begin
                errors++;
                $display("FAIL after_timeout: tmo=%b rdy=%b start=%b want 0 0 0", o_timeout, src_ready, o_start);
            end
        end
    endtask

    // Result arriving in the last wait cycle beats the timeout.
    task automatic test_result_tie();
        i_start = 1'b1;
        stream_frame(0, W * H, 0, 0);
        deliver_result(TO - 1, 11'd300, 11'd200);
        @(negedge i_clk);
        checks++;
        if (o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tie_timeout: tmo=%b want 0", o_timeout);
        end
    endtask

    task automatic test_abort_continuous();
        i_continuous = 1'b1;
        i_start = 1'b1;
        stream_frame(0, 3, 1, 0);
        deliver_result(1, 11'd11, 11'd22);
        i_continuous = 1'b0;
        stream_frame(30, W * H, 0, 0);
        deliver_result(4, 11'd1, NF);
    endtask

    task automatic test_reset_mid();
        bit no_end = 1;
        i_start = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge i_clk);
        i_start = 1'b0;
        src_valid = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 0 || o_start !== 0 || o_frame_end !== 0 || o_frame_start !== 0 ||
            src_ready !== 0 || o_done !== 0 || o_timeout !== 0 || o_cx !== NF || o_cy !== NF ||
            o_found !== 0 || o_frame_cnt !== 0 || o_r !== 0 || o_g !== 0 || o_b !== 0 ||
            o_x !== 0 || o_y !== 0) begin
            errors++;
            $display("FAIL mid_reset_values: v=%b rdy=%b xy=(%0d,%0d) cnt=%0d", o_valid, src_ready,
                     o_x, o_y, o_frame_cnt);
        end
        src_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            if (o_frame_end !== 1'b0) no_end = 0;
        end
        i_rst_n = 1'b1;
        exp_cnt = '0; exp_cx = NF; exp_cy = NF; exp_found = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            if (o_frame_end !== 1'b0 || src_ready !== 1'b0 || o_start !== 1'b0) no_end = 0;
        end
        checks++;
        if (!no_end) begin
            errors++;
            $display("FAIL mid_reset_quiet: activity seen during/after reset without i_start");
        end
        i_start = 1'b1;
        stream_frame(0, W * H, 0, 0);
        deliver_result(2, 11'd77, 11'd88);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps_not_found();
        test_ignored_inputs();
        test_timeout();
        test_result_tie();
        test_abort_continuous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter: WIDTH, 640, pixels per line.
REQ-002 Parameter: HEIGHT, 480, lines per frame.
REQ-003 Parameter: RES_TIMEOUT, 4096, maximum cycles to wait for a tracker result.
REQ-004 Parameter: NOT_FOUND, 2023, coordinate code meaning "no object".
REQ-005 Port list SHALL be:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  request one frame
- i_continuous  in  1  restart automatically after each frame
- i_abort  in  1  truncate the current frame
- src_valid  in  1  source pixel available
- src_r/src_g/src_b  in  8 each  source pixel
- src_ready  out  1  pixel accepted when src_valid && src_ready
- o_start  out  1  tracker start pulse
- o_valid  out  1  pixel output valid
- o_r/o_g/o_b  out  8 each  pixel
- o_x/o_y  out  11 each  pixel coordinate
- o_frame_start  out  1  marks pixel (0,0)
- o_frame_end  out  1  end-of-frame pulse
- res_valid  in  1  tracker result strobe
- res_x/res_y  in  11 each  tracker centroid
- o_cx/o_cy  out  11 each  latched centroid
- o_found  out  1  latched centroid is valid
- o_done  out  1  frame-complete pulse
- o_timeout  out  1  result-timeout pulse
- o_frame_cnt  out  16  completed-frame counter

Function
REQ-006 FSM states SHALL be IDLE, START, STREAM, FLUSH, END, WAIT_RES.
REQ-007 IDLE SHALL go to START when i_start=1.
REQ-008 START SHALL last exactly 1 cycle, SHALL drive o_start=1, and SHALL clear the x/y counters.
REQ-009 After START the FSM SHALL go to STREAM.
REQ-010 src_ready SHALL equal (state==STREAM) and SHALL be combinational from state only.
REQ-011 A pixel accepted in cycle t SHALL appear in cycle t+1 with o_valid=1, o_r/o_g/o_b=source data, and o_x/o_y=counter values at t.
REQ-012 o_frame_start SHALL be 1 only together with o_valid for pixel (0,0).
REQ-013 On each accept, x SHALL increment; at x=WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-014 Acceptance of pixel (WIDTH-1, HEIGHT-1) SHALL move the FSM to FLUSH.
REQ-015 FLUSH SHALL last 1 cycle, during which the last pixel is presented; the FSM SHALL then go to END.
REQ-016 END SHALL last 1 cycle with o_frame_end=1 and o_valid=0.
REQ-017 o_frame_end SHALL never coincide with o_valid.
REQ-018 o_valid SHALL be 0 in every cycle without a preceding accept; source stalls (src_valid=0) SHALL produce gaps with no counter change.
REQ-019 i_abort=1 in STREAM SHALL force FLUSH next cycle; a pixel accepted in that same cycle SHALL still be presented.
REQ-020 The truncated frame SHALL then emit END normally.
REQ-021 i_abort SHALL be ignored outside STREAM.
REQ-022 WAIT_RES SHALL count cycles from 0.
REQ-023 On res_valid=1 in WAIT_RES, o_cx/o_cy SHALL latch res_x/res_y, and o_found SHALL be set to (res_x!=NOT_FOUND && res_y!=NOT_FOUND).
REQ-024 On res_valid=1 in WAIT_RES, o_done SHALL pulse 1 cycle and o_frame_cnt SHALL increment, wrapping at 65535→0.
REQ-025 If the wait counter reaches RES_TIMEOUT-1 without res_valid, o_timeout SHALL pulse 1 cycle.
REQ-026 On timeout, o_cx/o_cy SHALL become NOT_FOUND, o_found=0, o_frame_cnt SHALL be unchanged, and o_done SHALL NOT pulse.
REQ-027 If res_valid and timeout occur in the same cycle, res_valid SHALL win.
REQ-028 On leaving WAIT_RES, the FSM SHALL go to START if i_continuous=1, else to IDLE.
REQ-029 res_valid outside WAIT_RES SHALL be ignored.
REQ-030 i_start outside IDLE SHALL be ignored.

Reset
REQ-031 Asynchronous reset SHALL force the FSM to IDLE and clear counters.
REQ-032 On reset, all pulse, valid and ready outputs SHALL be 0.
REQ-033 On reset, o_cx=o_cy=NOT_FOUND, o_found=0, o_frame_cnt=0, and o_r/o_g/o_b/o_x/o_y=0.
REQ-034 Reset mid-frame SHALL emit no o_frame_end.
REQ-035 After reset release, the block SHALL remain in IDLE until i_start=1.

Verification
REQ-036 Full frame, src_valid held 1, WIDTH=4/HEIGHT=2: o_start precedes 8 o_valid cycles (0,0)…(3,1); o_frame_end follows 1 cycle after (3,1); src_ready is high exactly 8 cycles.
REQ-037 Random src_valid gaps: output coordinates are strictly sequential with no duplicates; o_frame_start appears once, with (0,0).
REQ-038 res_valid with res_x=123, res_y=45 in WAIT_RES: o_cx=123, o_cy=45, o_found=1, 1-cycle o_done pulse, o_frame_cnt 0→1.
REQ-039 res_x=2023: o_found=0.
REQ-040 No result for RES_TIMEOUT cycles: single o_timeout pulse, o_cx=2023, o_frame_cnt unchanged, FSM returns to IDLE.
REQ-041 i_abort after 3 pixels: those 3 pixels are output, then o_frame_end 1 cycle after the last; with i_continuous=1, next o_start follows the result.
REQ-042 Reset asserted during STREAM: all outputs reach reset values immediately; no o_frame_end; the next i_start yields a frame beginning at (0,0).
